activation: RTL and testbench

//  Fixed-point neuron activation unit for the NN datapath, placed after each MAC accumulator.

---
 rtl/activation_pkg.sv | 42 ++++
 rtl/activation_sigmoid_plan.sv | 37 +++
 rtl/activation.sv | 60 ++++++
 tb/tb_activation.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/activation_pkg.sv
// Shared constants and types for the PLAN sigmoid activation unit.
// All segment thresholds and offsets are derived from FRAC_W, so the
// Q-format can change without touching the datapath. FRAC_W must be >= 5
// because the 0.84375 offset is built as 27 << (FRAC_W - 5).
package activation_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ABS_W  = DATA_W + 1;

  typedef logic signed [15:0] fix_t;
  typedef logic        [15:0] ufix_t;
  typedef logic [ABS_W-1:0]   abs_t;

  // Segment thresholds on |x|: 5.0, 2.375, 1.0
  localparam abs_t SEG_SAT_TH = abs_t'(32'd5  << FRAC_W);
  localparam abs_t SEG_HI_TH  = abs_t'(32'd19 << (FRAC_W - 3));
  localparam abs_t SEG_MID_TH = abs_t'(32'd1  << FRAC_W);

  // Segment offsets: 0.84375, 0.625, 0.5 and the saturation value 1.0
  localparam abs_t OFF_HI  = abs_t'(32'd27 << (FRAC_W - 5));
  localparam abs_t OFF_MID = abs_t'(32'd5  << (FRAC_W - 3));
  localparam abs_t OFF_LO  = abs_t'(32'd1  << (FRAC_W - 1));
  localparam abs_t ONE     = abs_t'(32'd1  << FRAC_W);

  // Slope shifts: 1/32, 1/8, 1/4
  localparam int SH_HI  = 5;
  localparam int SH_MID = 3;
  localparam int SH_LO  = 2;

  // Magnitude in one extra bit so the most negative input does not wrap.
  function automatic abs_t abs_value(input fix_t x);
    abs_t ext;
    ext = {x[DATA_W-1], x};
    if (x[DATA_W-1]) begin
      return (~ext) + abs_t'(1);
    end else begin
      return ext;
    end
  endfunction

endpackage

// File: rtl/activation_sigmoid_plan.sv
// Combinational PLAN sigmoid: magnitude, segment select, shift-add, and
// mirror about 0.5 for negative inputs (y(-x) = 1 - y(x)).
module sigmoid_plan
  import activation_pkg::*;
(
  input  fix_t  x_i,
  output ufix_t y_o
);

  abs_t a_s;
  abs_t mag_s;
  abs_t res_s;

  // Evaluate the piecewise-linear curve on |x| and mirror for negative x.
  always_comb begin
    a_s   = abs_value(x_i);
    mag_s = ONE;
    res_s = ONE;
    if (a_s >= SEG_SAT_TH) begin
      mag_s = ONE;
    end else if (a_s >= SEG_HI_TH) begin
      mag_s = (a_s >> SH_HI) + OFF_HI;
    end else if (a_s >= SEG_MID_TH) begin
      mag_s = (a_s >> SH_MID) + OFF_MID;
    end else begin
      mag_s = (a_s >> SH_LO) + OFF_LO;
    end
    // mag_s never exceeds ONE, so the mirror cannot underflow.
    if (x_i[DATA_W-1]) begin
      res_s = ONE - mag_s;
    end else begin
      res_s = mag_s;
    end
    y_o = ufix_t'(res_s);
  end

endmodule

// File: rtl/activation.sv
// Neuron activation unit: registered PLAN sigmoid with 1-cycle latency and
// a valid flag. Optional build macro ACTIVATION_RELU_EN adds the act_sel
// port, which selects ReLU (pass non-negative input, clamp negative to 0).
module activation
  import activation_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] act_in,
`ifdef ACTIVATION_RELU_EN
  input  logic              act_sel,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] act_out
);

  ufix_t             sig_s;
  logic [DATA_W-1:0] act_d;
  logic [DATA_W-1:0] act_q;
  logic              out_valid_q;

  sigmoid_plan u_sigmoid_plan (
    .x_i (fix_t'(act_in)),
    .y_o (sig_s)
  );

  // Next output word: new result on a valid sample, otherwise hold.
  always_comb begin
    act_d = act_q;
    if (in_valid) begin
`ifdef ACTIVATION_RELU_EN
      if (act_sel) begin
        act_d = act_in[DATA_W-1] ? {DATA_W{1'b0}} : act_in;
      end else begin
        act_d = sig_s;
      end
`else
      act_d = sig_s;
`endif
    end else begin
      act_d = act_q;
    end
  end

  // Output and valid registers; valid simply follows in_valid one cycle later.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      act_q       <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      act_q       <= act_d;
      out_valid_q <= in_valid;
    end
  end

  assign act_out   = act_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_activation.sv
// Scoreboard bench for activation: the driver pushes expected responses,
// a monitor pops and compares one cycle later.
module tb_activation;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] act_in = 16'h0000;
  logic        out_valid;
  logic [15:0] act_out;
`ifdef ACTIVATION_RELU_EN
  logic        act_sel = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  bit          exp_v_q[$];
  logic [15:0] exp_d_q[$];
  logic [15:0] held = 16'h0000;
  bit          mon_en = 1'b0;

  activation dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .act_in    (act_in),
`ifdef ACTIVATION_RELU_EN
    .act_sel   (act_sel),
`endif
    .out_valid (out_valid),
    .act_out   (act_out)
  );

  always #5 clk = ~clk;

  // Reference: sigmoid rules evaluated in plain integer arithmetic.
  function automatic logic [15:0] ref_sigmoid(input logic [15:0] x);
    int v;
    int a;
    int y;
    v = int'($signed(x));
    a = (v < 0) ? -v : v;
    if (a >= 1280)      y = 256;
    else if (a >= 608)  y = a / 32 + 216;
    else if (a >= 256)  y = a / 8 + 160;
    else                y = a / 4 + 128;
    if (v < 0) y = 256 - y;
    return 16'(y);
  endfunction

  function automatic logic [15:0] ref_relu(input logic [15:0] x);
    if ($signed(x) < 0) return 16'h0000;
    return x;
  endfunction

  task automatic drive(input bit v, input logic [15:0] x, input bit sel);
    @(negedge clk);
    in_valid = v;
    act_in   = x;
`ifdef ACTIVATION_RELU_EN
    act_sel  = sel;
`endif
    exp_v_q.push_back(v);
    if (v) begin
      exp_d_q.push_back(sel ? ref_relu(x) : ref_sigmoid(x));
    end
  endtask

  // Monitor: one expected entry per clocked cycle after it was driven.
  logic [15:0] exp_d;
  bit          exp_v;
  always @(posedge clk) begin
    #1;
    if (mon_en && exp_v_q.size() > 0) begin
      exp_v = exp_v_q.pop_front();
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL out_valid: got %b expected %b at %0t", out_valid, exp_v, $time);
      end
      if (exp_v) begin
        exp_d = exp_d_q.pop_front();
        held  = exp_d;
      end else begin
        exp_d = held;
      end
      checks++;
      if (act_out !== exp_d) begin
        errors++;
        $display("FAIL act_out: got %h expected %h (valid_exp=%b) at %0t", act_out, exp_d, exp_v, $time);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] dir_vec[14];
    dir_vec = '{16'h0000, 16'h0080, 16'h0100, 16'h0300, 16'h0500,
                16'hFF00, 16'hFD00, 16'h8000, 16'h7FFF,
                16'h025F, 16'h0260, 16'h04FF, 16'hFB00, 16'h00FF};

    // Reset state, no clock edge needed.
    #3;
    checks++;
    if (act_out !== 16'h0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: got valid=%b data=%h expected 0/0000", out_valid, act_out);
    end
    @(negedge clk);
    @(negedge clk);
    n_rst  = 1'b1;
    mon_en = 1'b1;

    // Centre, segments, symmetry and boundaries, back to back.
    foreach (dir_vec[i]) drive(1'b1, dir_vec[i], 1'b0);

    // Valid gap: output must hold while in_valid is low.
    drive(1'b1, 16'h0100, 1'b0);
    drive(1'b0, 16'h0500, 1'b0);
    drive(1'b0, 16'hFD00, 1'b0);
    drive(1'b1, 16'h0080, 1'b0);

`ifdef ACTIVATION_RELU_EN
    drive(1'b1, 16'h0123, 1'b1);
    drive(1'b1, 16'hFF00, 1'b1);
    drive(1'b1, 16'h0000, 1'b1);
    drive(1'b1, 16'h7FFF, 1'b1);
`endif

    // Randomised stream with boundary-biased values.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] x;
      bit          v;
      bit          s;
      v = ($urandom_range(3, 0) != 0);
      case ($urandom_range(3, 0))
        0:       x = 16'($urandom());
        1:       x = 16'($urandom_range(1400, 0));
        2:       x = 16'(-int'($urandom_range(1400, 0)));
        default: x = 16'($urandom_range(1300, 200));
      endcase
`ifdef ACTIVATION_RELU_EN
      s = $urandom_range(1, 0) != 0;
`else
      s = 1'b0;
`endif
      drive(v, x, s);
    end

    // Asynchronous reset mid-stream with in_valid held high.
    drive(1'b1, 16'h0300, 1'b0);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    in_valid = 1'b1;
    n_rst = 1'b0;
    #1;
    checks++;
    if (act_out !== 16'h0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got valid=%b data=%h expected 0/0000", out_valid, act_out);
    end
    @(negedge clk);
    exp_v_q.delete();
    exp_d_q.delete();
    held     = 16'h0000;
    in_valid = 1'b0;
    n_rst    = 1'b1;
    mon_en   = 1'b1;
    drive(1'b0, 16'h0500, 1'b0);
    drive(1'b0, 16'h0100, 1'b0);
    drive(1'b1, 16'hFF00, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_v_q.size() != 0; i++) @(posedge clk);
    #3;
    checks++;
    if (exp_v_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_v_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
